axi_mem_port_arbiter: RTL and testbench
=======================================

Name: axi_mem_port_arbiter

Overview:
- Shares the single memory port (mem_read/mem_write/address/data/strb) between the AXI slave's write-burst engine and read-burst engine.
- Sequences beats from one owner at a time, with round-robin burst-level arbitration and a fairness cap on burst length.
- Tracks fixed-latency read returns and routes mem_read_data back to the read engine with a valid strobe.
- Sits between the AW/W/AR channel FSMs and the memory macro.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- MEM_RD_LATENCY, 1, cycles from mem_read asserted to mem_read_data valid; range 1..8.
- MAX_BEATS, 16, maximum beats granted in one tenure while the other side waits; range 1..256.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_areset  in  1  synchronous active-high reset
- wr_req  in  1  write engine has a beat to issue
- wr_last  in  1  current write beat is the last of the burst
- wr_addr  in  ADDR_WIDTH  write beat byte address
- wr_data  in  DATA_WIDTH  write beat data
- wr_strb  in  DATA_WIDTH/8  write byte strobes
- wr_gnt  out  1  write beat accepted this cycle
- rd_req  in  1  read engine has a beat to issue
- rd_last  in  1  current read beat is the last of the burst
- rd_addr  in  ADDR_WIDTH  read beat byte address
- rd_gnt  out  1  read beat accepted this cycle
- rd_data  out  DATA_WIDTH  returned read data
- rd_data_valid  out  1  rd_data valid; no backpressure
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  memory address
- mem_write_data  out  DATA_WIDTH  memory write data
- mem_write_strb  out  DATA_WIDTH/8  memory byte strobes
- mem_read_data  in  DATA_WIDTH  memory read data, MEM_RD_LATENCY after mem_read

Behaviour:
- One clock, s_axi_aclk. Reset s_axi_areset is synchronous and active-high.
- Reset values:
  - All outputs are 0. State is IDLE, beat count is 0, last_owner is RD (so write wins the first tie), read-latency pipe is cleared.
- States: IDLE, WR_OWN, RD_OWN.
- From IDLE:
  - wr_req only -> WR_OWN.
  - rd_req only -> RD_OWN.
  - Both requesting -> the side that is not last_owner wins.
  - Neither -> stay in IDLE.
  - No grant is issued in IDLE, so arbitration costs one cycle.
- WR_OWN:
  - wr_gnt = wr_req (combinational); rd_gnt = 0.
  - Each granted beat increments the beat count.
- RD_OWN: symmetric to WR_OWN (rd_gnt = rd_req, wr_gnt = 0).
- Release: the owner's tenure ends on the cycle a granted beat satisfies either condition below.
  - The beat has *_last = 1.
  - The beat count reaches MAX_BEATS-1 while the other side's req = 1.
- On release:
  - last_owner takes the current owner; beat count clears.
  - Next state is the other owner if its req = 1, otherwise IDLE. No IDLE bubble on a handoff.
- Owner idle: if the owner's req = 0 and the other's req = 1, the owner releases immediately (no grant that cycle). The owner keeps the port while both are 0.
- Fairness split: a burst cut by the MAX_BEATS cap resumes later without a new arbitration penalty beyond normal round-robin. The engines hold their own address and length state.
- Memory drive (registered, 1-cycle latency from grant):
  - mem_write <= wr_gnt; mem_read <= rd_gnt.
  - mem_address <= granted beat's address.
  - mem_write_data and mem_write_strb <= wr_data and wr_strb when wr_gnt, else 0.
  - mem_read and mem_write are never both 1.
- Read return:
  - MEM_RD_LATENCY-deep shift register of mem_read.
  - rd_data_valid is the tap at MEM_RD_LATENCY.
  - rd_data = mem_read_data, registered when the tap fires, else holds.
  - Total latency rd_gnt -> rd_data_valid = MEM_RD_LATENCY + 1 cycles.
  - One valid per granted read, in order.
- Mid-operation reset: in-flight read returns are dropped (no rd_data_valid after reset). Any partially-issued burst is abandoned; the engines are reset by the same signal.
- Address: passed through unmodified. Alignment and wrap handling are the engines' responsibility.

Test Plan:
- Write burst alone: wr_req for 4 beats, last on beat 4, addr 0x40000000+4n -> IDLE 1 cycle, then wr_gnt 4 consecutive cycles; mem_write 4 cycles lagging by 1; mem_address 0x40000000..0x4000000C; return to IDLE.
- Read latency: MEM_RD_LATENCY=2, single read at 0x40000010, memory returns 0xDEADBEEF -> rd_gnt at cycle t; mem_read at t+1; rd_data_valid with rd_data=0xDEADBEEF at t+3, exactly one pulse.
- Simultaneous requests from reset: wr_req and rd_req both set, 2-beat bursts each -> write granted first (2 beats), read follows with no IDLE gap; mem_read and mem_write never overlap.
- Fairness cap: MAX_BEATS=4, write burst of 10 beats, rd_req asserted from cycle 0 -> 4 write beats, 1-beat read burst, then remaining 6 write beats; total write beats = 10.
- Reset mid-read: MEM_RD_LATENCY=3, reset asserted 1 cycle after mem_read -> all outputs 0 next cycle; no rd_data_valid afterwards; the next grant requires the IDLE arbitration cycle.

Source files
------------

// File: rtl/axi_mem_port_arbiter_if.sv
// Beat-request, grant, memory-drive and read-return signals shared by the
// AXI write/read burst engines, the port arbiter and the memory macro.
interface axi_mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      wr_req;
    logic                      wr_last;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_strb;
    logic                      wr_gnt;
    logic                      rd_req;
    logic                      rd_last;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic                      rd_gnt;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_data_valid;
    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_WIDTH-1:0]     mem_address;
    logic [DATA_WIDTH-1:0]     mem_write_data;
    logic [DATA_WIDTH/8-1:0]   mem_write_strb;
    logic [DATA_WIDTH-1:0]     mem_read_data;

    // Arbiter side.
    modport slave (
        input  wr_req, wr_last, wr_addr, wr_data, wr_strb,
        input  rd_req, rd_last, rd_addr, mem_read_data,
        output wr_gnt, rd_gnt, rd_data, rd_data_valid,
        output mem_read, mem_write, mem_address, mem_write_data, mem_write_strb
    );

    // Engines plus memory side.
    modport master (
        output wr_req, wr_last, wr_addr, wr_data, wr_strb,
        output rd_req, rd_last, rd_addr, mem_read_data,
        input  wr_gnt, rd_gnt, rd_data, rd_data_valid,
        input  mem_read, mem_write, mem_address, mem_write_data, mem_write_strb
    );
endinterface

// File: rtl/axi_mem_port_arbiter.sv
// Round-robin, burst-level sharing of one memory port between the AXI write
// and read burst engines, with a beat cap per tenure and fixed-latency read return.
//
// state  | meaning
// IDLE   | no owner; one arbitration cycle, no grant issued
// WR_OWN | write engine owns the port, wr_gnt = wr_req
// RD_OWN | read engine owns the port, rd_gnt = rd_req
module axi_mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_RD_LATENCY = 1,
    parameter int MAX_BEATS      = 16
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_areset,
    axi_mem_port_arbiter_if.slave  bus
);

    localparam int SW    = DATA_WIDTH / 8;
    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_OWN = 2'd1,
        RD_OWN = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      last_rd_q, last_rd_d;
    logic                      wr_gnt, rd_gnt, cap_hit;

    logic                      mem_write_q, mem_read_q;
    logic [ADDR_WIDTH-1:0]     mem_address_q;
    logic [DATA_WIDTH-1:0]     mem_write_data_q;
    logic [SW-1:0]             mem_write_strb_q;
    logic [MEM_RD_LATENCY-1:0] rd_pipe_q;
    logic [DATA_WIDTH-1:0]     rd_hold_q;
    logic                      rd_valid;

    assign wr_gnt  = (state_q == WR_OWN) && bus.wr_req;
    assign rd_gnt  = (state_q == RD_OWN) && bus.rd_req;
    assign cap_hit = (cnt_q == CNT_CAP);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_rd_d = last_rd_q;
        case (state_q)
            IDLE: begin
                if (bus.wr_req && (!bus.rd_req || last_rd_q)) begin
                    state_d = WR_OWN;
                end else if (bus.rd_req) begin
                    state_d = RD_OWN;
                end
            end
            WR_OWN: begin
                if (bus.wr_req) begin
                    if (bus.wr_last || (cap_hit && bus.rd_req)) begin
                        state_d   = bus.rd_req ? RD_OWN : IDLE;
                        cnt_d     = '0;
                        last_rd_d = 1'b0;
                    end else if (!cap_hit) begin
                        // Saturate so a late request from the other side still sees the cap.
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (bus.rd_req) begin
                    state_d   = RD_OWN;
                    cnt_d     = '0;
                    last_rd_d = 1'b0;
                end
            end
            RD_OWN: begin
                if (bus.rd_req) begin
                    if (bus.rd_last || (cap_hit && bus.wr_req)) begin
                        state_d   = bus.wr_req ? WR_OWN : IDLE;
                        cnt_d     = '0;
                        last_rd_d = 1'b1;
                    end else if (!cap_hit) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (bus.wr_req) begin
                    state_d   = WR_OWN;
                    cnt_d     = '0;
                    last_rd_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            last_rd_q        <= 1'b1;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_strb_q <= '0;
            rd_pipe_q        <= '0;
            rd_hold_q        <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            last_rd_q        <= last_rd_d;
            mem_write_q      <= wr_gnt;
            mem_read_q       <= rd_gnt;
            mem_address_q    <= wr_gnt ? bus.wr_addr : (rd_gnt ? bus.rd_addr : '0);
            mem_write_data_q <= wr_gnt ? bus.wr_data : '0;
            mem_write_strb_q <= wr_gnt ? bus.wr_strb : '0;
            rd_pipe_q[0]     <= mem_read_q;
            for (int i = 1; i < MEM_RD_LATENCY; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            if (rd_valid) begin
                rd_hold_q <= bus.mem_read_data;
            end
        end
    end

    // Tap fires in the same cycle the memory presents the data.
    assign rd_valid = rd_pipe_q[MEM_RD_LATENCY-1];

    assign bus.wr_gnt         = wr_gnt;
    assign bus.rd_gnt         = rd_gnt;
    assign bus.rd_data_valid  = rd_valid;
    assign bus.rd_data        = rd_valid ? bus.mem_read_data : rd_hold_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign bus.mem_write_strb = mem_write_strb_q;

endmodule

// File: tb/tb_axi_mem_port_arbiter.sv
// Directed bench for axi_mem_port_arbiter: behavioural burst engines, a
// fixed-latency memory model, per-cycle traces checked against hand-derived values.
module tb_axi_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_RD_LATENCY(LAT), .MAX_BEATS(MB)
    ) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .bus         (bus)
    );

    // Memory: data is a fixed function of the address seen LAT cycles earlier.
    logic [AW-1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= bus.mem_address;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a == 32'h4000_0010) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
    endfunction
    assign bus.mem_read_data = mem_fn(apipe[LAT-1]);

    int tests = 0;
    int fails = 0;

    int wr_rem, wr_idx, rd_rem, rd_idx;
    logic [AW-1:0] wr_base, rd_base;

    int cyc;
    logic          wg_tr [32];
    logic          rg_tr [32];
    logic          mw_tr [32];
    logic          mr_tr [32];
    logic          rv_tr [32];
    logic [31:0]   ad_tr [32];
    logic [31:0]   wd_tr [32];
    logic [3:0]    ws_tr [32];
    logic [31:0]   rd_tr [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive engine outputs, sample everything at negedge, advance on grant.
    task automatic cycle();
        bus.wr_req  = (wr_rem != 0);
        bus.wr_last = (wr_rem == 1);
        bus.wr_addr = wr_base + 32'(wr_idx * 4);
        bus.wr_data = bus.wr_addr ^ 32'h1234_5678;
        bus.wr_strb = 4'(wr_idx + 1);
        bus.rd_req  = (rd_rem != 0);
        bus.rd_last = (rd_rem == 1);
        bus.rd_addr = rd_base + 32'(rd_idx * 4);
        @(negedge clk);
        wg_tr[cyc] = bus.wr_gnt;
        rg_tr[cyc] = bus.rd_gnt;
        mw_tr[cyc] = bus.mem_write;
        mr_tr[cyc] = bus.mem_read;
        rv_tr[cyc] = bus.rd_data_valid;
        ad_tr[cyc] = bus.mem_address;
        wd_tr[cyc] = bus.mem_write_data;
        ws_tr[cyc] = bus.mem_write_strb;
        rd_tr[cyc] = bus.rd_data;
        if (bus.wr_gnt === 1'b1) begin wr_rem--; wr_idx++; end
        if (bus.rd_gnt === 1'b1) begin rd_rem--; rd_idx++; end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_rem = 0; wr_idx = 0; rd_rem = 0; rd_idx = 0;
        wr_base = '0; rd_base = '0;
        bus.wr_req = 1'b0; bus.wr_last = 1'b0; bus.wr_addr = '0;
        bus.wr_data = '0; bus.wr_strb = '0;
        bus.rd_req = 1'b0; bus.rd_last = 1'b0; bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst wr_gnt", 32'(bus.wr_gnt), 0);
        chk("rst rd_gnt", 32'(bus.rd_gnt), 0);
        chk("rst mem_write", 32'(bus.mem_write), 0);
        chk("rst mem_read", 32'(bus.mem_read), 0);
        chk("rst mem_address", bus.mem_address, 0);
        chk("rst mem_write_data", bus.mem_write_data, 0);
        chk("rst mem_write_strb", 32'(bus.mem_write_strb), 0);
        chk("rst rd_data_valid", 32'(bus.rd_data_valid), 0);
        chk("rst rd_data", bus.rd_data, 0);
        @(posedge clk);
        #1;

        // Write burst alone: 4 beats from 0x40000000
        cyc = 0; wr_rem = 4; wr_idx = 0; wr_base = 32'h4000_0000;
        repeat (7) cycle();
        for (int c = 0; c < 7; c++) begin
            chk($sformatf("wr4 wr_gnt c%0d", c), 32'(wg_tr[c]), 32'((c >= 1 && c <= 4) ? 1 : 0));
            chk($sformatf("wr4 mem_write c%0d", c), 32'(mw_tr[c]), 32'((c >= 2 && c <= 5) ? 1 : 0));
            chk($sformatf("wr4 mem_read c%0d", c), 32'(mr_tr[c]), 0);
        end
        for (int c = 2; c <= 5; c++)
            chk($sformatf("wr4 mem_address c%0d", c), ad_tr[c], 32'h4000_0000 + 32'((c - 2) * 4));
        chk("wr4 wdata beat0", wd_tr[2], 32'h5234_5678);
        chk("wr4 strb beat0", 32'(ws_tr[2]), 1);
        chk("wr4 strb beat1", 32'(ws_tr[3]), 2);
        chk("wr4 wdata beat3", wd_tr[5], 32'h5234_5674);

        // Single read at 0x40000010, latency 2: gnt c1, mem_read c2, valid c4
        cyc = 0; rd_rem = 1; rd_idx = 0; rd_base = 32'h4000_0010;
        repeat (8) cycle();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("rd1 rd_gnt c%0d", c), 32'(rg_tr[c]), 32'((c == 1) ? 1 : 0));
            chk($sformatf("rd1 mem_read c%0d", c), 32'(mr_tr[c]), 32'((c == 2) ? 1 : 0));
            chk($sformatf("rd1 rd_data_valid c%0d", c), 32'(rv_tr[c]), 32'((c == 4) ? 1 : 0));
        end
        chk("rd1 mem_address", ad_tr[2], 32'h4000_0010);
        chk("rd1 mem_write_data zero", wd_tr[2], 0);
        chk("rd1 rd_data", rd_tr[4], 32'hDEAD_BEEF);
        chk("rd1 rd_data hold", rd_tr[6], 32'hDEAD_BEEF);

        // Simultaneous 2-beat bursts from reset: write first, read handed over with no gap
        do_reset();
        wr_rem = 2; wr_base = 32'h4000_0000;
        rd_rem = 2; rd_base = 32'h4000_0100;
        repeat (9) cycle();
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("sim wr_gnt c%0d", c), 32'(wg_tr[c]), 32'((c == 1 || c == 2) ? 1 : 0));
            chk($sformatf("sim rd_gnt c%0d", c), 32'(rg_tr[c]), 32'((c == 3 || c == 4) ? 1 : 0));
            chk($sformatf("sim no overlap c%0d", c), 32'(mw_tr[c] & mr_tr[c]), 0);
            chk($sformatf("sim rd_data_valid c%0d", c), 32'(rv_tr[c]), 32'((c == 6 || c == 7) ? 1 : 0));
        end
        chk("sim mem_read c4", 32'(mr_tr[4]), 1);
        chk("sim mem_read c5", 32'(mr_tr[5]), 1);
        chk("sim rd_data beat0", rd_tr[6], 32'hE5A5_0100);
        chk("sim rd_data beat1", rd_tr[7], 32'hE5A5_0104);

        // Fairness cap MAX_BEATS=4: 10-beat write split 4 / read 1 / 6
        do_reset();
        wr_rem = 10; wr_base = 32'h4000_0200;
        rd_rem = 1;  rd_base = 32'h4000_0300;
        repeat (14) cycle();
        n = 0;
        for (int c = 0; c < 14; c++) begin
            chk($sformatf("cap wr_gnt c%0d", c), 32'(wg_tr[c]),
                32'(((c >= 1 && c <= 4) || (c >= 6 && c <= 11)) ? 1 : 0));
            chk($sformatf("cap rd_gnt c%0d", c), 32'(rg_tr[c]), 32'((c == 5) ? 1 : 0));
            chk($sformatf("cap no overlap c%0d", c), 32'(mw_tr[c] & mr_tr[c]), 0);
            if (wg_tr[c] === 1'b1) n++;
        end
        chk("cap total write beats", 32'(n), 10);
        chk("cap beat5 address", ad_tr[7], 32'h4000_0210);
        chk("cap beat10 address", ad_tr[12], 32'h4000_0224);
        chk("cap read valid", 32'(rv_tr[8]), 1);
        chk("cap read data", rd_tr[8], 32'hE5A5_0300);

        // Reset one cycle after mem_read: return dropped, IDLE cycle before next grant
        cyc = 0; rd_rem = 1; rd_idx = 0; rd_base = 32'h4000_0010;
        repeat (3) cycle();
        chk("mrst rd_gnt c1", 32'(rg_tr[1]), 1);
        chk("mrst mem_read c2", 32'(mr_tr[2]), 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rd_rem = 1; rd_idx = 0;
        repeat (6) cycle();
        chk("mrst mem_read c4", 32'(mr_tr[4]), 0);
        chk("mrst mem_write c4", 32'(mw_tr[4]), 0);
        chk("mrst mem_address c4", ad_tr[4], 0);
        chk("mrst rd_data c4", rd_tr[4], 0);
        chk("mrst rd_gnt c4 idle", 32'(rg_tr[4]), 0);
        chk("mrst rd_gnt c5", 32'(rg_tr[5]), 1);
        for (int c = 3; c < 10; c++)
            chk($sformatf("mrst rd_data_valid c%0d", c), 32'(rv_tr[c]), 32'((c == 8) ? 1 : 0));
        chk("mrst rd_data c8", rd_tr[8], 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
